counter_timer_prog: RTL and testbench

//  Programmable counter/timer with a prescaler and a 3-state FSM (IDLE/RUN/DONE).

---
 rtl/counter_timer_prog.sv | 111 +++++++++++
 tb/tb_counter_timer_prog.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_prog.sv
// Programmable counter/timer: prescaled up/down counting with auto-reload,
// one-shot and free-run modes, a registered terminal-count tick and IDLE/RUN/DONE status.
module counter_timer_prog #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clr,
  input  logic [1:0]               mode,
  input  logic                     dir,
  input  logic [WIDTH-1:0]         threshold,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic [WIDTH-1:0]         count,
  output logic                     tick,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_FREE    = 2'd2;

  logic [1:0]               state;
  logic [PRESCALE_BITS-1:0] pre_cnt;
  logic [1:0]               mode_sh;
  logic                     dir_sh;
  logic [WIDTH-1:0]         threshold_sh;
  logic [PRESCALE_BITS-1:0] prescale_sh;

  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] next_count;
  logic             at_term;
  logic             is_oneshot;
  logic             is_free;
  logic             step;

  // Everything here works from the shadowed configuration, so live input
  // changes during RUN cannot disturb the running count.
  always_comb begin
    terminal   = dir_sh ? '0 : threshold_sh;
    reload     = dir_sh ? threshold_sh : '0;
    stepped    = dir_sh ? (count - 1'b1) : (count + 1'b1);
    at_term    = (count == terminal);
    is_oneshot = (mode_sh == MODE_ONESHOT);
    is_free    = (mode_sh == MODE_FREE);
    next_count = stepped;
    if (!is_free && at_term) begin
      next_count = reload;
    end
    step = (state == RUN) && (pre_cnt == prescale_sh);
  end

  // Commands resolve as clr > stop > start; tick defaults low so it can
  // only ever last a single cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      pre_cnt      <= '0;
      mode_sh      <= '0;
      dir_sh       <= 1'b0;
      threshold_sh <= '0;
      prescale_sh  <= '0;
      tick         <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr) begin
        count   <= '0;
        pre_cnt <= '0;
        state   <= IDLE;
      end else if (stop) begin
        if (state != IDLE) begin
          state   <= IDLE;
          pre_cnt <= '0;
        end
      end else if (start) begin
        mode_sh      <= mode;
        dir_sh       <= dir;
        threshold_sh <= threshold;
        prescale_sh  <= prescale;
        pre_cnt      <= '0;
        state        <= RUN;
        count        <= dir ? threshold : '0;
      end else if (state == RUN) begin
        if (step) begin
          pre_cnt <= '0;
          if (is_oneshot && at_term) begin
            state <= DONE;
          end else begin
            count <= next_count;
            tick  <= (next_count == terminal);
          end
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_timer_prog.sv
// Randomised and directed bench for counter_timer_prog, compared each cycle
// against a behavioural model of the counting rules.
module tb_counter_timer_prog;

  localparam int W  = 8;
  localparam int PB = 4;
  localparam int M  = 1 << W;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic          clr;
  logic [1:0]    mode;
  logic          dir;
  logic [W-1:0]  threshold;
  logic [PB-1:0] prescale;
  logic [W-1:0]  count;
  logic          tick;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // model state
  int m_count, m_pc, m_mode, m_dir, m_thr, m_pre;
  bit m_tick, m_busy, m_done;

  counter_timer_prog #(.WIDTH(W), .PRESCALE_BITS(PB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clr(clr),
    .mode(mode), .dir(dir), .threshold(threshold), .prescale(prescale),
    .count(count), .tick(tick), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void modelReset();
    m_count = 0; m_pc = 0; m_mode = 0; m_dir = 0; m_thr = 0; m_pre = 0;
    m_tick = 0; m_busy = 0; m_done = 0;
  endfunction

  // One count step of the timer, straight from the mode rules.
  function automatic void modelCountStep();
    int term, nxt;
    bit oneshot, free;
    term    = m_dir ? 0 : m_thr;
    oneshot = (m_mode == 1);
    free    = (m_mode == 2);
    if (oneshot && m_count == term) begin
      m_busy = 0;
      m_done = 1;
      return;
    end
    if (!free && m_count == term) nxt = m_dir ? m_thr : 0;
    else nxt = m_dir ? (m_count + M - 1) % M : (m_count + 1) % M;
    m_tick  = (nxt == term);
    m_count = nxt;
  endfunction

  function automatic void modelClock();
    m_tick = 0;
    if (clr) begin
      m_count = 0; m_pc = 0; m_busy = 0; m_done = 0;
    end else if (stop) begin
      if (m_busy || m_done) begin
        m_busy = 0; m_done = 0; m_pc = 0;
      end
    end else if (start) begin
      m_mode = (mode == 2'd3) ? 0 : int'(mode);
      m_dir = dir; m_thr = threshold; m_pre = prescale;
      m_pc = 0; m_busy = 1; m_done = 0;
      m_count = dir ? int'(threshold) : 0;
    end else if (m_busy) begin
      if (m_pc == m_pre) begin
        m_pc = 0;
        modelCountStep();
      end else begin
        m_pc++;
      end
    end
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, "_count"}, count, m_count);
    checkOutput({tag, "_tick"}, tick, m_tick);
    checkOutput({tag, "_busy"}, busy, m_busy);
    checkOutput({tag, "_done"}, done, m_done);
  endtask

  // Drive inputs for one cycle, clock, advance the model and compare.
  task automatic applyStimulus(input string tag, input bit s_start, input bit s_stop,
                               input bit s_clr, input int s_mode, input bit s_dir,
                               input int s_thr, input int s_pre);
    start = s_start; stop = s_stop; clr = s_clr;
    mode = 2'(s_mode); dir = s_dir; threshold = W'(s_thr); prescale = PB'(s_pre);
    @(posedge clk);
    modelClock();
    #1;
    checkAll(tag);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, mode, dir, threshold, prescale);
  endtask

  task automatic asyncReset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    start = 0; stop = 0; clr = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    checkAll({tag, "_hold"});
  endtask

  int tick_gap, last_tick;

  initial begin
    reset_n = 1'b0; start = 0; stop = 0; clr = 0;
    mode = 0; dir = 0; threshold = 0; prescale = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");
    reset_n = 1'b1;

    // up auto-reload thr=4: independent constant sequence 1,2,3,4,0,...
    applyStimulus("t2_start", 1, 0, 0, 0, 0, 4, 0);
    checkOutput("t2_first", count, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("t2", 0, 0, 0, 0, 0, 4, 0);
      checkOutput("t2_seq", count, (i + 1) % 5);
      checkOutput("t2_tick", tick, ((i + 1) % 5) == 4);
    end

    // async reset mid-count
    asyncReset("t1_async");

    // down one-shot thr=3 prescale=2
    applyStimulus("t3_start", 1, 0, 0, 1, 1, 3, 2);
    idleCycles("t3", 16);
    checkOutput("t3_done", done, 1);
    checkOutput("t3_held", count, 0);

    // free-run up thr=10: tick period 256 steps
    applyStimulus("t4_start", 1, 0, 0, 2, 0, 10, 0);
    last_tick = -1; tick_gap = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus("t4", 0, 0, 0, 2, 0, 10, 0);
      if (tick) begin
        if (last_tick >= 0) tick_gap = i - last_tick;
        last_tick = i;
      end
    end
    checkOutput("t4_period", tick_gap, 256);

    // priority and restart
    applyStimulus("t5_all", 1, 1, 1, 0, 0, 5, 0);
    checkOutput("t5_prio_count", count, 0);
    checkOutput("t5_prio_busy", busy, 0);
    applyStimulus("t5_start", 1, 0, 0, 0, 0, 4, 1);
    idleCycles("t5_run", 5);
    applyStimulus("t5_restart", 1, 0, 0, 0, 0, 7, 0);
    checkOutput("t5_restart_count", count, 0);
    for (int i = 0; i < 20; i++) applyStimulus("t5_live", 0, 0, 0, 0, 0, 2 + (i % 3), 0);

    // thr=0 up auto-reload, then stop
    applyStimulus("t6_start", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("t6", 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t6_tick_each", tick, 1);
    end
    applyStimulus("t6_stop", 0, 1, 0, 0, 0, 0, 0);
    idleCycles("t6_frozen", 6);
    checkOutput("t6_no_busy", busy, 0);

    // one-shot up thr=0: DONE on first step without tick
    applyStimulus("t6b_start", 1, 0, 0, 1, 0, 0, 0);
    applyStimulus("t6b_step", 0, 0, 0, 1, 0, 0, 0);
    checkOutput("t6b_done", done, 1);
    checkOutput("t6b_tick", tick, 0);

    // random phase; live inputs wander freely to exercise shadowing
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) asyncReset("rnd_reset");
      applyStimulus("rnd",
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 89) == 0,
                    $urandom_range(0, 3),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12),
                    $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
